// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one byte-wide synchronous RAM port between instruction fetch
// (32-bit reads) and memory access (1/2/4-byte loads and stores). Transfers are
// serialized as little-endian bytes; load results are sign/zero-extended.
module mem_port_arbiter #(
    parameter int unsigned ADDR_W      = 32,
    parameter bit          IF_PRIORITY = 1'b0
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_rdy,
    input  logic              i_if_req,
    input  logic [ADDR_W-1:0] i_if_addr,
    output logic              o_if_done,
    output logic [31:0]       o_if_data,
    input  logic              i_ma_req,
    input  logic              i_ma_we,
    input  logic [2:0]        i_ma_width,
    input  logic [ADDR_W-1:0] i_ma_addr,
    input  logic [31:0]       i_ma_wdata,
    output logic              o_ma_done,
    output logic [31:0]       o_ma_rdata,
    input  logic [7:0]        i_mem_din,
    output logic [7:0]        o_mem_dout,
    output logic [ADDR_W-1:0] o_mem_a,
    output logic              o_mem_wr,
    output logic              o_busy
);

    typedef enum logic [1:0] {StIdle, StBusy, StTail, StDone} state_e;

    state_e            r_state;
    state_e            w_state_nxt;
    logic [1:0]        r_cnt;
    logic [1:0]        r_last;     // index of the final byte (N-1)
    logic [1:0]        r_size;     // ma_width[1:0] of the owner, 00 for fetch
    logic              r_own_ma;
    logic              r_we;
    logic              r_zext;
    logic [ADDR_W-1:0] r_base;
    logic [31:0]       r_wdata;
    logic [31:0]       r_buf;
    logic [31:0]       r_if_data;
    logic [31:0]       r_ma_rdata;

    logic              w_start;
    logic              w_grant_ma;
    logic [1:0]        w_cap_idx;
    logic [31:0]       w_word;
    logic [31:0]       w_ext;

    assign w_start    = i_if_req | i_ma_req;
    // MA takes the port unless IF is also asking and IF has priority
    assign w_grant_ma = i_ma_req & (~i_if_req | ~IF_PRIORITY);
    // RAM data lags its address by one cycle, so BUSY stores the previous byte
    assign w_cap_idx  = r_cnt - 2'd1;

    assign o_if_data  = r_if_data;
    assign o_ma_rdata = r_ma_rdata;

    // State register; rdy low freezes the FSM
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            r_state <= StIdle;
        end else if (i_rdy) begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic: IDLE -> BUSY -> (TAIL for loads) -> DONE -> IDLE
    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            StIdle: if (w_start) w_state_nxt = StBusy;
            StBusy: if (r_cnt == r_last) w_state_nxt = r_we ? StDone : StTail;
            StTail: w_state_nxt = StDone;
            StDone: w_state_nxt = StIdle;
            default: w_state_nxt = StIdle;
        endcase
    end

    // Assembled load word: buffered bytes plus the byte arriving in TAIL
    always_comb begin
        w_word = r_buf;
        w_word[{r_last, 3'b000} +: 8] = i_mem_din;
    end

    // Sign/zero extension of byte and half loads
    always_comb begin
        w_ext = w_word;
        unique case (r_size)
            2'b01:   w_ext = r_zext ? {24'd0, w_word[7:0]} : {{24{w_word[7]}}, w_word[7:0]};
            2'b10:   w_ext = r_zext ? {16'd0, w_word[15:0]} : {{16{w_word[15]}}, w_word[15:0]};
            default: w_ext = w_word;
        endcase
    end

    // Request latch, byte counter, load buffer and result registers
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            r_cnt      <= 2'd0;
            r_last     <= 2'd0;
            r_size     <= 2'd0;
            r_own_ma   <= 1'b0;
            r_we       <= 1'b0;
            r_zext     <= 1'b0;
            r_base     <= '0;
            r_wdata    <= 32'd0;
            r_buf      <= 32'd0;
            r_if_data  <= 32'd0;
            r_ma_rdata <= 32'd0;
        end else if (i_rdy) begin
            unique case (r_state)
                StIdle: begin
                    if (w_start) begin
                        r_cnt    <= 2'd0;
                        r_own_ma <= w_grant_ma;
                        if (w_grant_ma) begin
                            r_base  <= i_ma_addr;
                            r_we    <= i_ma_we;
                            r_zext  <= i_ma_width[2];
                            r_size  <= i_ma_width[1:0];
                            r_wdata <= i_ma_wdata;
                            unique case (i_ma_width[1:0])
                                2'b01:   r_last <= 2'd0;
                                2'b10:   r_last <= 2'd1;
                                default: r_last <= 2'd3;
                            endcase
                        end else begin
                            r_base <= i_if_addr;
                            r_we   <= 1'b0;
                            r_zext <= 1'b0;
                            r_size <= 2'b00;
                            r_last <= 2'd3;
                        end
                    end
                end
                StBusy: begin
                    r_cnt <= r_cnt + 2'd1;
                    if (!r_we && (r_cnt != 2'd0)) begin
                        r_buf[{w_cap_idx, 3'b000} +: 8] <= i_mem_din;
                    end
                end
                StTail: begin
                    if (r_own_ma) r_ma_rdata <= w_ext;
                    else          r_if_data  <= w_word;
                end
                default: ;
            endcase
        end
    end

    // Outputs decoded from state; RAM port is quiet outside BUSY
    always_comb begin
        o_mem_a    = '0;
        o_mem_wr   = 1'b0;
        o_mem_dout = 8'd0;
        o_if_done  = 1'b0;
        o_ma_done  = 1'b0;
        o_busy     = (r_state != StIdle);
        unique case (r_state)
            StBusy: begin
                o_mem_a = r_base + ADDR_W'(r_cnt);
                if (r_we) begin
                    o_mem_wr   = i_rdy;
                    o_mem_dout = r_wdata[{r_cnt, 3'b000} +: 8];
                end
            end
            StDone: begin
                o_if_done = ~r_own_ma;
                o_ma_done = r_own_ma;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: directed latency/bus-sequence tests plus
// randomized concurrent IF/MA traffic checked by a scoreboard against a byte-array model.
module tb_mem_port_arbiter;

    logic        clk = 1'b0;
    logic        rst, rdy;
    logic        if_req, ma_req, ma_we;
    logic [2:0]  ma_width;
    logic [31:0] if_addr, ma_addr, ma_wdata;
    logic        if_done, ma_done, mem_wr, busy;
    logic [31:0] if_data, ma_rdata, mem_a;
    logic [7:0]  mem_din, mem_dout;

    always #5 clk = ~clk;

    mem_port_arbiter #(.ADDR_W(32), .IF_PRIORITY(1'b0)) u_dut (
        .i_clk(clk), .i_rst(rst), .i_rdy(rdy),
        .i_if_req(if_req), .i_if_addr(if_addr), .o_if_done(if_done), .o_if_data(if_data),
        .i_ma_req(ma_req), .i_ma_we(ma_we), .i_ma_width(ma_width), .i_ma_addr(ma_addr),
        .i_ma_wdata(ma_wdata), .o_ma_done(ma_done), .o_ma_rdata(ma_rdata),
        .i_mem_din(mem_din), .o_mem_dout(mem_dout), .o_mem_a(mem_a), .o_mem_wr(mem_wr),
        .o_busy(busy)
    );

    int n_chk  = 0;
    int n_fail = 0;

    // RAM seen by the DUT (10-bit index, aliases the full address space)
    logic [7:0] ram [0:1023];
    logic       poke_en = 1'b0;
    logic [9:0] poke_a;
    logic [7:0] poke_d;
    // Reference memory, updated when a transaction is issued
    logic [7:0] ref_mem [0:1023];

    always @(posedge clk) begin
        if (poke_en) ram[poke_a] <= poke_d;
        else if (rst === 1'b1 && rdy === 1'b1) begin
            if (mem_wr) ram[mem_a[9:0]] <= mem_dout;
            mem_din <= ram[mem_a[9:0]];
        end
    end

    function automatic void chk(input string name, input logic [31:0] act,
                                input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endfunction

    function automatic int nbytes(input logic [2:0] w);
        case (w[1:0])
            2'b01:   return 1;
            2'b10:   return 2;
            default: return 4;
        endcase
    endfunction

    function automatic logic [31:0] model_load(input logic [31:0] a, input logic [2:0] w);
        logic [31:0] v, x;
        int n;
        n = nbytes(w);
        v = 32'd0;
        for (int i = 0; i < n; i++) begin
            x = a + i;
            v = v | (32'(ref_mem[x[9:0]]) << (8 * i));
        end
        if (!w[2] && n == 1 && v[7])  v = v | 32'hFFFFFF00;
        if (!w[2] && n == 2 && v[15]) v = v | 32'hFFFF0000;
        return v;
    endfunction

    function automatic void model_store(input logic [31:0] a, input logic [2:0] w,
                                       input logic [31:0] d);
        logic [31:0] x;
        for (int i = 0; i < nbytes(w); i++) begin
            x = a + i;
            ref_mem[x[9:0]] = d[8*i +: 8];
        end
    endfunction

    // Scoreboard queues: one outstanding-response queue per requester
    typedef struct packed {
        logic        st;
        logic [31:0] d;
    } ma_e_t;
    logic [31:0] if_q [$];
    ma_e_t       ma_q [$];

    always @(negedge clk) begin : monitor
        logic [31:0] e;
        ma_e_t       m;
        if (rst === 1'b1 && rdy === 1'b1) begin
            if (if_done) begin
                if (if_q.size() == 0) begin
                    n_chk++; n_fail++;
                    $display("FAIL if_done unexpected: got done, expected none");
                end else begin
                    e = if_q.pop_front();
                    chk("if_data", if_data, e);
                end
            end
            if (ma_done) begin
                if (ma_q.size() == 0) begin
                    n_chk++; n_fail++;
                    $display("FAIL ma_done unexpected: got done, expected none");
                end else begin
                    m = ma_q.pop_front();
                    if (!m.st) chk("ma_rdata", ma_rdata, m.d);
                end
            end
        end
    end

    logic [31:0] a_log    [0:31];
    logic        wr_log   [0:31];
    logic [7:0]  dout_log [0:31];

    // One request on one side; logs bus per cycle, C0 = cycle the request is sampled
    task automatic do_req(input bit is_ma, input bit we, input logic [2:0] width,
                          input logic [31:0] addr, input logic [31:0] wdata,
                          input int stall_at, output int done_k);
        done_k = -1;
        for (int k = 0; k < 32; k++) begin
            a_log[k] = 32'd0; wr_log[k] = 1'b0; dout_log[k] = 8'd0;
        end
        @(posedge clk); #1;
        if (is_ma) begin
            ma_we = we; ma_width = width; ma_addr = addr; ma_wdata = wdata; ma_req = 1'b1;
        end else begin
            if_addr = addr; if_req = 1'b1;
        end
        for (int k = 0; k < 30; k++) begin
            @(negedge clk);
            a_log[k] = mem_a; wr_log[k] = mem_wr; dout_log[k] = mem_dout;
            if (rdy && (is_ma ? ma_done : if_done)) begin
                done_k = k;
                break;
            end
            @(posedge clk); #1;
            rdy = !(stall_at >= 0 && k + 1 >= stall_at && k + 1 < stall_at + 3);
        end
        @(posedge clk); #1;
        if_req = 1'b0; ma_req = 1'b0; rdy = 1'b1;
        if (done_k < 0) begin
            n_chk++; n_fail++;
            $display("FAIL request timeout: got no done, expected done within 30 cycles");
        end
    endtask

    task automatic poke(input logic [31:0] a, input logic [7:0] d);
        @(posedge clk); #1;
        poke_a = a[9:0]; poke_d = d; poke_en = 1'b1;
        ref_mem[a[9:0]] = d;
        @(posedge clk); #1;
        poke_en = 1'b0;
    endtask

    function automatic int wr_count();
        int c = 0;
        for (int k = 0; k < 32; k++) c += int'(wr_log[k]);
        return c;
    endfunction

    bit stop = 1'b0;

    initial begin : main
        int dk, ma_k, if_k, nm, ni, bad;
        logic [31:0] w, extra;
        rst = 1'b0; rdy = 1'b1; if_req = 1'b0; ma_req = 1'b0; ma_we = 1'b0;
        ma_width = 3'd0; if_addr = 32'd0; ma_addr = 32'd0; ma_wdata = 32'd0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset mem_a", mem_a, 32'd0);
        chk("reset ctrl", {28'd0, if_done, ma_done, mem_wr, busy}, 32'd0);
        chk("reset data", if_data | ma_rdata | {24'd0, mem_dout}, 32'd0);

        // Fill RAM and reference with random bytes
        @(posedge clk); #1;
        poke_en = 1'b1;
        for (int i = 0; i < 1024; i++) begin
            poke_a = 10'(i); poke_d = 8'($urandom); ref_mem[i] = poke_d;
            @(posedge clk); #1;
        end
        poke_en = 1'b0;
        rst = 1'b1;
        repeat (2) @(posedge clk);

        // 1: IF word read
        poke(32'h100, 8'h13); poke(32'h101, 8'h05); poke(32'h102, 8'h00); poke(32'h103, 8'h00);
        if_q.push_back(32'h0000_0513);
        do_req(1'b0, 1'b0, 3'b000, 32'h100, 32'd0, -1, dk);
        chk("t1 done cycle", dk, 32'd6);
        for (int i = 0; i < 4; i++) chk("t1 mem_a", a_log[i+1], 32'h100 + i);
        chk("t1 no write", wr_count(), 32'd0);

        // 2: byte/half loads with extension
        poke(32'h20, 8'h80);
        ma_q.push_back('{st: 1'b0, d: 32'hFFFF_FF80});
        do_req(1'b1, 1'b0, 3'b001, 32'h20, 32'd0, -1, dk);
        chk("t2 lb done cycle", dk, 32'd3);
        ma_q.push_back('{st: 1'b0, d: 32'h0000_0080});
        do_req(1'b1, 1'b0, 3'b101, 32'h20, 32'd0, -1, dk);
        poke(32'h20, 8'h34); poke(32'h21, 8'hF2);
        ma_q.push_back('{st: 1'b0, d: 32'hFFFF_F234});
        do_req(1'b1, 1'b0, 3'b010, 32'h20, 32'd0, -1, dk);
        chk("t2 lh done cycle", dk, 32'd4);

        // 3: word and byte stores
        w = 32'hDEAD_BEEF;
        model_store(32'h40, 3'b000, w);
        ma_q.push_back('{st: 1'b1, d: 32'd0});
        do_req(1'b1, 1'b1, 3'b000, 32'h40, w, -1, dk);
        chk("t3 sw done cycle", dk, 32'd5);
        chk("t3 sw write cycles", wr_count(), 32'd4);
        for (int i = 0; i < 4; i++) begin
            chk("t3 sw mem_a", a_log[i+1], 32'h40 + i);
            chk("t3 sw mem_dout", {24'd0, dout_log[i+1]}, {24'd0, w[8*i +: 8]});
        end
        model_store(32'h40, 3'b001, w);
        ma_q.push_back('{st: 1'b1, d: 32'd0});
        do_req(1'b1, 1'b1, 3'b001, 32'h40, w, -1, dk);
        chk("t3 sb done cycle", dk, 32'd2);
        chk("t3 sb write cycles", wr_count(), 32'd1);
        chk("t3 sb bus", {a_log[1][23:0], dout_log[1]}, 32'h0000_40EF);
        ma_q.push_back('{st: 1'b0, d: model_load(32'h40, 3'b000)});
        do_req(1'b1, 1'b0, 3'b000, 32'h40, 32'd0, -1, dk);

        // 4: simultaneous requests, MA wins
        ma_q.push_back('{st: 1'b0, d: model_load(32'h100, 3'b000)});
        if_q.push_back(model_load(32'h20, 3'b000));
        @(posedge clk); #1;
        ma_we = 1'b0; ma_width = 3'b000; ma_addr = 32'h100; if_addr = 32'h20;
        ma_req = 1'b1; if_req = 1'b1;
        ma_k = -1; if_k = -1; nm = 0; ni = 0;
        for (int k = 0; k < 24; k++) begin
            @(negedge clk);
            if (k == 1) chk("t4 first grant", mem_a, 32'h100);
            if (ma_done) begin nm++; if (ma_k < 0) ma_k = k; end
            if (if_done) begin ni++; if (if_k < 0) if_k = k; end
            @(posedge clk); #1;
            if (ma_k >= 0) ma_req = 1'b0;
            if (if_k >= 0) if_req = 1'b0;
        end
        chk("t4 ma done cycle", ma_k, 32'd6);
        chk("t4 if done cycle", if_k, 32'd13);
        chk("t4 done counts", {nm[15:0], ni[15:0]}, {16'd1, 16'd1});

        // 5: rdy low for 3 cycles mid word read
        if_q.push_back(model_load(32'h100, 3'b000));
        do_req(1'b0, 1'b0, 3'b000, 32'h100, 32'd0, 2, dk);
        chk("t5 done cycle", dk, 32'd9);
        for (int i = 2; i < 6; i++) chk("t5 frozen mem_a", a_log[i], 32'h101);
        chk("t5 no write", wr_count(), 32'd0);

        // Randomized concurrent traffic: IF reads 0x000-0x0FF, MA uses 0x200-0x2FF
        fork
            begin
                fork
                    begin : if_drv
                        int g, t;
                        logic [31:0] a;
                        for (int i = 0; i < 40; i++) begin
                            g = $urandom_range(0, 3);
                            repeat (g) @(posedge clk);
                            @(posedge clk); #1;
                            a = $urandom_range(0, 252);
                            if_addr = a;
                            if_q.push_back(model_load(a, 3'b000));
                            if_req = 1'b1;
                            t = 0;
                            do begin @(negedge clk); t++; end
                            while (!(rdy && if_done) && t < 300);
                            if (!(rdy && if_done)) begin
                                n_chk++; n_fail++;
                                $display("FAIL rand if timeout: got no done, expected done");
                            end
                            @(posedge clk); #1;
                            if_req = 1'b0;
                        end
                    end
                    begin : ma_drv
                        int g, t;
                        logic [31:0] a, d;
                        logic [2:0] wsel;
                        logic [2:0] wt [0:5];
                        wt[0] = 3'b001; wt[1] = 3'b010; wt[2] = 3'b000;
                        wt[3] = 3'b011; wt[4] = 3'b101; wt[5] = 3'b110;
                        for (int i = 0; i < 50; i++) begin
                            g = $urandom_range(0, 3);
                            repeat (g) @(posedge clk);
                            @(posedge clk); #1;
                            a = 32'h200 + $urandom_range(0, 252);
                            d = $urandom;
                            wsel = wt[$urandom_range(0, 5)];
                            ma_we = 1'($urandom_range(0, 1));
                            ma_addr = a; ma_wdata = d; ma_width = wsel;
                            if (ma_we) begin
                                model_store(a, wsel, d);
                                ma_q.push_back('{st: 1'b1, d: 32'd0});
                            end else begin
                                ma_q.push_back('{st: 1'b0, d: model_load(a, wsel)});
                            end
                            ma_req = 1'b1;
                            t = 0;
                            do begin @(negedge clk); t++; end
                            while (!(rdy && ma_done) && t < 300);
                            if (!(rdy && ma_done)) begin
                                n_chk++; n_fail++;
                                $display("FAIL rand ma timeout: got no done, expected done");
                            end
                            @(posedge clk); #1;
                            ma_req = 1'b0;
                        end
                    end
                join
                stop = 1'b1;
            end
            begin
                while (!stop) begin
                    @(posedge clk); #1;
                    rdy = ($urandom_range(0, 3) != 0);
                end
            end
        join
        @(posedge clk); #1;
        rdy = 1'b1;
        repeat (2) @(posedge clk);

        // 6: reset during the second byte of a word store
        @(posedge clk); #1;
        ma_we = 1'b1; ma_width = 3'b000; ma_addr = 32'h40; ma_wdata = 32'hCAFE_F00D;
        ma_req = 1'b1;
        repeat (2) @(posedge clk);
        #2;
        chk("t6 second byte addr", mem_a, 32'h41);
        rst = 1'b0;
        #1;
        chk("t6 reset mem_a", mem_a, 32'd0);
        chk("t6 reset ctrl", {28'd0, if_done, ma_done, mem_wr, busy}, 32'd0);
        chk("t6 reset data", if_data | ma_rdata | {24'd0, mem_dout}, 32'd0);
        ref_mem[10'h40] = 8'h0D;  // first byte already written; not rolled back
        ma_req = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        extra = 32'd0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            extra = extra | {29'd0, ma_done, if_done, busy};
        end
        chk("t6 quiet after reset", extra, 32'd0);

        // Address wrap-around on a word fetch
        if_q.push_back(model_load(32'hFFFF_FFFE, 3'b000));
        do_req(1'b0, 1'b0, 3'b000, 32'hFFFF_FFFE, 32'd0, -1, dk);
        chk("t6 wrap done cycle", dk, 32'd6);
        chk("t6 wrap a0", a_log[1], 32'hFFFF_FFFE);
        chk("t6 wrap a1", a_log[2], 32'hFFFF_FFFF);
        chk("t6 wrap a2", a_log[3], 32'h0000_0000);
        chk("t6 wrap a3", a_log[4], 32'h0000_0001);

        repeat (3) @(posedge clk);
        chk("if queue drained", if_q.size(), 32'd0);
        chk("ma queue drained", ma_q.size(), 32'd0);
        bad = 0;
        for (int i = 0; i < 1024; i++) if (ram[i] !== ref_mem[i]) bad++;
        chk("ram contents", bad, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
